itu_trs_decoder: RTL and testbench

ITU_TRS_DECODER -- requirements
Module: itu_trs_decoder

---
 rtl/itu_trs_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_itu_trs_decoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itu_trs_decoder.sv
// rtl/itu_trs_decoder.sv - BT.656/BT.1120 TRS decoder: active-video extraction and field measurement
// Define ITU_XY_PROTECT_CHECK_EN to reject XY words whose protection bits are inconsistent.

module itu_trs_decoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int MAX_WIDTH        = 1920,
  parameter int MAX_HEIGHT       = 1080
) (
  input  logic                                        clk_itu_i,
  input  logic                                        rst_n,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] itu_data_i,
  input  logic                                        en_i,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [15:0]                                 width_o,
  output logic [15:0]                                 height_o,
  output logic [3:0]                                  interlaced_o,
  output logic                                        locked_o,
  output logic                                        xy_err_o
);

  localparam int B  = BITS_PER_SYMBOL;
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);
  localparam logic [15:0] MAX_H = 16'(MAX_HEIGHT);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ONES   = 2'd1,
    S_ZERO1  = 2'd2,
    S_ZERO2  = 2'd3
  } trs_state_e;

  trs_state_e    state_q, state_d;
  logic          active_q, active_d;
  logic          v_q, v_d;
  logic [15:0]   pix_q, pix_d;
  logic [15:0]   line_q, line_d;
  logic [15:0]   line_w_q, line_w_d;
  logic          meas_valid_q, meas_valid_d;
  logic [15:0]   width_q, width_d;
  logic [15:0]   height_q, height_d;
  logic [1:0]    intl_q, intl_d;
  logic          locked_q, locked_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hold_v_q, hold_v_d;
  logic          hold_sop_q, hold_sop_d;
  logic [DW-1:0] dout_data_q, dout_data_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_sop_q, dout_sop_d;
  logic          dout_eop_q, dout_eop_d;

  logic [B-1:0]  sym_hi;
  logic          is_ones, is_zero;
  logic          xy_beat, xy_ok, xy_take;
  logic          xy_f, xy_v, xy_h;
  logic          sav_open, line_close, beat_in, field_end;
  logic          match, last_line;

  // Only the upper symbol carries the TRS decision in both BT.656 and BT.1120.
  assign sym_hi  = itu_data_i[DW-1 -: B];
  assign is_ones = (sym_hi == {B{1'b1}});
  assign is_zero = (sym_hi == {B{1'b0}});
  assign xy_beat = (state_q == S_ZERO2);
  assign xy_f    = sym_hi[B-2];
  assign xy_v    = sym_hi[B-3];
  assign xy_h    = sym_hi[B-4];

`ifdef ITU_XY_PROTECT_CHECK_EN
  logic xy_err_q, xy_err_d;

  assign xy_ok = (sym_hi[B-5] == (xy_v ^ xy_h)) &&
                 (sym_hi[B-6] == (xy_f ^ xy_h)) &&
                 (sym_hi[B-7] == (xy_f ^ xy_v)) &&
                 (sym_hi[B-8] == (xy_f ^ xy_v ^ xy_h));
  assign xy_err_d = xy_beat && !xy_ok;
  assign xy_err_o = xy_err_q;
`else
  assign xy_ok    = 1'b1;
  assign xy_err_o = 1'b0;
`endif

  assign xy_take    = xy_beat && xy_ok;
  assign sav_open   = xy_take && !xy_h && !xy_v;
  assign line_close = active_q && is_ones;
  assign beat_in    = active_q && !is_ones;
  assign field_end  = xy_take && xy_v && !v_q;
  assign match      = meas_valid_q && (line_w_q == width_q) && (line_q == height_q) &&
                      (line_q != 16'd0) && (line_w_q != 16'd0);
  assign last_line  = (height_q != 16'd0) && (line_q == height_q - 16'd1);

  // A mismatching beat may itself start a new preamble, so it is re-tested for all-ones.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SEARCH: state_d = is_ones ? S_ONES : S_SEARCH;
      S_ONES:   state_d = is_zero ? S_ZERO1 : (is_ones ? S_ONES : S_SEARCH);
      S_ZERO1:  state_d = is_zero ? S_ZERO2 : (is_ones ? S_ONES : S_SEARCH);
      default:  state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    active_d     = active_q;
    v_d          = v_q;
    pix_d        = pix_q;
    line_d       = line_q;
    line_w_d     = line_w_q;
    meas_valid_d = meas_valid_q;
    width_d      = width_q;
    height_d     = height_q;
    intl_d       = intl_q;
    locked_d     = locked_q;

    if (line_close) begin
      active_d = 1'b0;
    end else if (sav_open) begin
      active_d = 1'b1;
    end
    if (xy_take) begin
      v_d = xy_v;
    end

    if (line_close) begin
      pix_d = 16'd0;
    end else if (beat_in && (pix_q != MAX_W)) begin
      pix_d = pix_q + 16'd1;
    end

    if (line_close && (pix_q != 16'd0)) begin
      line_w_d = pix_q;
    end

    if (field_end) begin
      line_d = 16'd0;
    end else if (line_close && (pix_q != 16'd0) && (line_q != MAX_H)) begin
      line_d = line_q + 16'd1;
    end

    // Field boundary: publish measurement and re-evaluate lock (en_i only matters here).
    if (field_end) begin
      width_d      = line_w_q;
      height_d     = line_q;
      intl_d       = {meas_valid_q && (xy_f != intl_q[0]), xy_f};
      meas_valid_d = 1'b1;
      locked_d     = en_i && match;
    end
  end

  // The hold stage delays each active beat so the line-ending preamble can tag it with eop.
  always_comb begin
    hold_v_d     = beat_in;
    hold_d       = beat_in ? itu_data_i : hold_q;
    hold_sop_d   = beat_in ? ((line_q == 16'd0) && (pix_q == 16'd0)) : hold_sop_q;
    dout_data_d  = hold_v_q ? hold_q : dout_data_q;
    dout_valid_d = hold_v_q && locked_q;
    dout_sop_d   = hold_v_q && locked_q && hold_sop_q;
    dout_eop_d   = hold_v_q && locked_q && line_close && last_line;
  end

  always_ff @(posedge clk_itu_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SEARCH;
      active_q     <= 1'b0;
      v_q          <= 1'b1;
      pix_q        <= 16'd0;
      line_q       <= 16'd0;
      line_w_q     <= 16'd0;
      meas_valid_q <= 1'b0;
      width_q      <= 16'd0;
      height_q     <= 16'd0;
      intl_q       <= 2'b00;
      locked_q     <= 1'b0;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      hold_sop_q   <= 1'b0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
`ifdef ITU_XY_PROTECT_CHECK_EN
      xy_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      v_q          <= v_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      line_w_q     <= line_w_d;
      meas_valid_q <= meas_valid_d;
      width_q      <= width_d;
      height_q     <= height_d;
      intl_q       <= intl_d;
      locked_q     <= locked_d;
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      hold_sop_q   <= hold_sop_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_eop_q   <= dout_eop_d;
`ifdef ITU_XY_PROTECT_CHECK_EN
      xy_err_q     <= xy_err_d;
`endif
    end
  end

  assign dout_data    = dout_data_q;
  assign dout_valid   = dout_valid_q;
  assign dout_sop     = dout_sop_q;
  assign dout_eop     = dout_eop_q;
  assign width_o      = width_q;
  assign height_o     = height_q;
  assign interlaced_o = {intl_q, 2'b00};
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_itu_trs_decoder.sv
// tb/tb_itu_trs_decoder.sv - directed field-table bench for itu_trs_decoder (BT.656 8-bit and BT.1120 10-bit)

module tb_itu_trs_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [7:0]  d8;
  logic [19:0] d20;

  logic [7:0]  o8_data;
  logic        o8_valid, o8_sop, o8_eop, o8_locked, o8_xy;
  logic [15:0] o8_w, o8_h;
  logic [3:0]  o8_i;
  logic [19:0] o10_data;
  logic        o10_valid, o10_sop, o10_eop, o10_locked, o10_xy;
  logic [15:0] o10_w, o10_h;
  logic [3:0]  o10_i;

  itu_trs_decoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1)) u_dut8 (
    .clk_itu_i(clk), .rst_n(rst_n), .itu_data_i(d8), .en_i(en),
    .dout_data(o8_data), .dout_valid(o8_valid), .dout_sop(o8_sop), .dout_eop(o8_eop),
    .width_o(o8_w), .height_o(o8_h), .interlaced_o(o8_i), .locked_o(o8_locked), .xy_err_o(o8_xy)
  );

  itu_trs_decoder #(.BITS_PER_SYMBOL(10), .SYMBOLS_PER_BEAT(2), .MAX_WIDTH(16), .MAX_HEIGHT(1080)) u_dut10 (
    .clk_itu_i(clk), .rst_n(rst_n), .itu_data_i(d20), .en_i(en),
    .dout_data(o10_data), .dout_valid(o10_valid), .dout_sop(o10_sop), .dout_eop(o10_eop),
    .width_o(o10_w), .height_o(o10_h), .interlaced_o(o10_i), .locked_o(o10_locked), .xy_err_o(o10_xy)
  );

  int mode = 0;
  logic [19:0] s_data;
  logic        s_valid, s_sop, s_eop, s_locked, s_xy;
  logic [15:0] s_w, s_h;
  logic [3:0]  s_i;

  always_comb begin
    if (mode == 0) begin
      s_data = {12'h000, o8_data}; s_valid = o8_valid; s_sop = o8_sop; s_eop = o8_eop;
      s_locked = o8_locked; s_xy = o8_xy; s_w = o8_w; s_h = o8_h; s_i = o8_i;
    end else begin
      s_data = o10_data; s_valid = o10_valid; s_sop = o10_sop; s_eop = o10_eop;
      s_locked = o10_locked; s_xy = o10_xy; s_w = o10_w; s_h = o10_h; s_i = o10_i;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Input history: beat driven now (h0) and the two before it, with tags {eol, first, active}.
  logic [19:0] h0 = '0, h1 = '0, h2 = '0;
  logic [2:0]  t0 = '0, t1 = '0, t2 = '0;
  int dcnt = 0;

  int n_valid = 0, n_sop = 0, n_eop = 0, n_xy = 0, pos_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid) begin
        n_valid++;
        if (!t2[0] || s_data != h2) pos_err++;
      end
      if (s_sop) begin
        n_sop++;
        if (!t2[1] || !s_valid) pos_err++;
      end
      if (s_eop) begin
        n_eop++;
        if (!t2[2] || !s_valid) pos_err++;
      end
      if (s_xy) n_xy++;
    end
  end

  task automatic drive(input logic [19:0] d, input logic [2:0] tag);
    @(posedge clk);
    #1;
    h2 = h1; t2 = t1;
    h1 = h0; t1 = t0;
    h0 = d;  t0 = tag;
    if (mode == 0) d8 = d[7:0];
    else d20 = d;
  endtask

  function automatic logic [7:0] xy8(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [19:0] b_ones();
    return (mode == 0) ? 20'h000FF : 20'hFFFFF;
  endfunction

  function automatic logic [19:0] b_blank();
    return (mode == 0) ? 20'h00080 : {10'h040, 10'h200};
  endfunction

  function automatic logic [19:0] b_xy(input logic f, input logic v, input logic h, input logic bad);
    logic [7:0] x;
    x = xy8(f, v, h);
    if (bad) x[0] = ~x[0];
    return (mode == 0) ? {12'h000, x} : {x, 2'b00, x, 2'b00};
  endfunction

  function automatic logic [19:0] b_act(input int n);
    logic [7:0] a8;
    logic [9:0] hi, lo;
    a8 = 8'h10 + 8'(n % 224);
    hi = 10'h040 + 10'(n % 896);
    lo = 10'h040 + 10'((n * 7) % 896);
    return (mode == 0) ? {12'h000, a8} : {hi, lo};
  endfunction

  task automatic send_trs(input logic f, input logic v, input logic h, input logic bad);
    drive(b_ones(), 3'b000);
    drive(20'h00000, 3'b000);
    drive(20'h00000, 3'b000);
    drive(b_xy(f, v, h, bad), 3'b000);
  endtask

  task automatic send_line(input logic f, input logic v, input int width, input logic first, input logic bad);
    send_trs(f, v, 1'b1, bad);
    repeat (4) drive(b_blank(), 3'b000);
    send_trs(f, v, 1'b0, 1'b0);
    for (int i = 0; i < width; i++) begin
      if (v) begin
        drive(b_blank(), 3'b000);
      end else begin
        drive(b_act(dcnt), {i == width - 1, first && (i == 0), 1'b1});
        dcnt++;
      end
    end
  endtask

  // Active lines first, then two V=1 lines whose first EAV ends the field.
  task automatic send_field(input logic f, input int lines, input int width, input logic bad_blank);
    for (int l = 0; l < lines; l++) send_line(f, 1'b0, width, l == 0, 1'b0);
    for (int b = 0; b < 2; b++) send_line(f, 1'b1, width, 1'b0, bad_blank && (b == 1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, s_valid, 0);
    check({tag, "_sop"}, s_sop, 0);
    check({tag, "_eop"}, s_eop, 0);
    check({tag, "_data"}, s_data, 0);
    check({tag, "_width"}, s_w, 0);
    check({tag, "_height"}, s_h, 0);
    check({tag, "_intl"}, s_i, 0);
    check({tag, "_locked"}, s_locked, 0);
    check({tag, "_xyerr"}, s_xy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    d8 = '0;
    d20 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         mode;
    bit         rst;
    bit         f;
    int         lines;
    int         width;
    bit         en;
    int         ew;
    int         eh;
    logic [3:0] ei;
    bit         el;
    int         ev;
    int         es;
    int         ee;
  } vec_t;

  vec_t vt[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int v0, s0, e0, x0;
    rst_n = 1'b0;
    en    = 1'b1;
    d8    = '0;
    d20   = '0;

    //        mode rst f lines width en  ew  eh  ei       el  ev   es ee
    vt[0]  = '{0, 1, 0, 6, 24, 1, 24, 6, 4'b0000, 0,   0, 0, 0};
    vt[1]  = '{0, 0, 0, 6, 24, 1, 24, 6, 4'b0000, 1,   0, 0, 0};
    vt[2]  = '{0, 0, 0, 6, 24, 1, 24, 6, 4'b0000, 1, 144, 1, 1};
    vt[3]  = '{0, 0, 0, 4, 24, 1, 24, 4, 4'b0000, 0,  96, 1, 0};
    vt[4]  = '{0, 0, 0, 4, 24, 1, 24, 4, 4'b0000, 1,   0, 0, 0};
    vt[5]  = '{0, 0, 0, 4, 24, 1, 24, 4, 4'b0000, 1,  96, 1, 1};
    vt[6]  = '{0, 0, 0, 4, 24, 0, 24, 4, 4'b0000, 0,  96, 1, 1};
    vt[7]  = '{0, 0, 0, 4, 24, 0, 24, 4, 4'b0000, 0,   0, 0, 0};
    vt[8]  = '{0, 0, 0, 4, 24, 1, 24, 4, 4'b0000, 1,   0, 0, 0};
    vt[9]  = '{0, 0, 1, 4, 24, 1, 24, 4, 4'b1100, 1,  96, 1, 1};
    vt[10] = '{0, 0, 0, 4, 24, 1, 24, 4, 4'b1000, 1,  96, 1, 1};
    vt[11] = '{0, 0, 1, 4, 24, 1, 24, 4, 4'b1100, 1,  96, 1, 1};
    vt[12] = '{1, 1, 0, 5, 20, 1, 16, 5, 4'b0000, 0,   0, 0, 0};
    vt[13] = '{1, 0, 0, 5, 20, 1, 16, 5, 4'b0000, 1,   0, 0, 0};
    vt[14] = '{1, 0, 0, 5, 20, 1, 16, 5, 4'b0000, 1, 100, 1, 1};

    for (int i = 0; i < 15; i++) begin
      mode = vt[i].mode;
      if (vt[i].rst) do_reset();
      en = vt[i].en;
      v0 = n_valid; s0 = n_sop; e0 = n_eop;
      send_field(vt[i].f, vt[i].lines, vt[i].width, 1'b0);
      check($sformatf("v%0d_width", i), s_w, vt[i].ew);
      check($sformatf("v%0d_height", i), s_h, vt[i].eh);
      check($sformatf("v%0d_intl", i), s_i, vt[i].ei);
      check($sformatf("v%0d_locked", i), s_locked, vt[i].el);
      check($sformatf("v%0d_nvalid", i), n_valid - v0, vt[i].ev);
      check($sformatf("v%0d_nsop", i), n_sop - s0, vt[i].es);
      check($sformatf("v%0d_neop", i), n_eop - e0, vt[i].ee);
      check($sformatf("v%0d_position", i), pos_err, 0);
    end

    // Asynchronous reset in the middle of an active line of a locked stream.
    en = 1'b1;
    fork
      send_field(1'b0, 5, 20, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #2;
        check("pre_rst_valid", s_valid, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midline");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    join
    check("partial_height", s_h, 3);
    check("partial_width", s_w, 16);
    check("partial_locked", s_locked, 0);

    v0 = n_valid;
    send_field(1'b0, 5, 20, 1'b0);
    check("relock1_locked", s_locked, 0);
    check("relock1_height", s_h, 5);
    send_field(1'b0, 5, 20, 1'b0);
    check("relock2_locked", s_locked, 1);
    check("relock_nvalid", n_valid - v0, 0);

    // Corrupted protection bits on a blanking EAV.
    v0 = n_valid; s0 = n_sop; e0 = n_eop; x0 = n_xy;
    send_field(1'b0, 5, 20, 1'b1);
    check("xy_nvalid", n_valid - v0, 100);
    check("xy_nsop", n_sop - s0, 1);
    check("xy_neop", n_eop - e0, 1);
    check("xy_locked", s_locked, 1);
    check("xy_height", s_h, 5);
`ifdef ITU_XY_PROTECT_CHECK_EN
    check("xy_err_pulses", n_xy - x0, 1);
`else
    check("xy_err_pulses", n_xy - x0, 0);
`endif
    check("final_position", pos_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
